uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Transmit scheduler that shares the single `uart_tx` serializer between four byte-producing requesters. It arbitrates among pending requests, presents the winning byte on `uart_data`, and generates a clean rising edge on `uart_tx_en`. It then holds off for one full frame time before serving the next byte, because `uart_tx` exposes no busy flag. It sits directly in front of `uart_tx`, and its outputs connect one-to-one to `uart_data` / `uart_tx_en`.

## Interface
- SYS_CLK_FRE, 50_000_000, system clock frequency in Hz
- BPS, 9_600, baud rate; must match the attached `uart_tx`
- GUARD, 16, extra idle clocks appended to each frame window
- Derived (localparam): BPS_CNT = SYS_CLK_FRE/BPS; FRAME_CNT = 10*BPS_CNT + GUARD (52096 at defaults)

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  4  per-requester byte pending; bit i belongs to requester i
- req_data  in  32  packed bytes; requester i drives [8*i+7:8*i]
- req_ready  out  4  one-cycle accept pulse; byte i is consumed when req_valid[i] && req_ready[i]
- uart_data  out  8  byte presented to `uart_tx`
- uart_tx_en  out  1  transmit enable to `uart_tx`; only its rising edge is significant
- busy  out  1  high from the accept cycle through the end of the frame window
- grant_id  out  2  index of the requester last accepted

## Operation
- State machine: IDLE, START, WAIT.
- IDLE:
  - If any req_valid bit is set, select the winner, pulse req_ready[winner], register uart_data <= winner byte, register grant_id <= winner, set busy=1, go to START.
  - Otherwise stay in IDLE with uart_tx_en=0.
- START: uart_tx_en <= 1, frame counter <= 0, go to WAIT.
- WAIT:
  - Counter increments each cycle while uart_tx_en is held high.
  - When the counter reaches FRAME_CNT-1: uart_tx_en <= 0, busy <= 0, go to IDLE.
- Round-robin arbitration: search starts at (last_grant+1) mod 4, increasing with wrap. last_grant resets to 3, so requester 0 has first priority after reset.
- Frame counter is 20 bits. FRAME_CNT must be < 2^20, which holds for BPS ≥ 600 at 50 MHz.
- uart_data stays constant from the accept cycle until the next accept. This satisfies `uart_tx` capturing data one cycle after the en edge.
- req_valid that deasserts without an accept is dropped silently; requesters hold valid and data until accepted.
- req_valid changes while busy are ignored until IDLE.

## Timing
- Reset values: uart_data=8'h00, uart_tx_en=0, req_ready=4'h0, busy=0, grant_id=2'd0, state=IDLE, counter=0, last_grant=3.
- Accept cycle is the first IDLE cycle with any valid set (registered outputs visible next edge). uart_tx_en rises one cycle after req_ready pulses.
- uart_tx_en stays high for exactly FRAME_CNT cycles.
- uart_tx_en is low for at least 2 cycles between frames (IDLE + accept/START), guaranteeing a distinct rising edge for every byte.
- Back-to-back throughput: one byte per FRAME_CNT+2 cycles.
- At most one req_ready bit is high in any cycle.
- Reset mid-frame: all outputs return to reset values immediately, and the accepted byte is lost. Drive `uart_tx` from the same reset so its line returns to idle-high.

## Configuration
- UART_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, with the lowest index winning; last_grant is neither kept nor used.
  - Undefined (default): round-robin as described.
- All other behaviour is identical in both builds.

## Test plan
- Single request: reset, then req_valid=4'b0100 with byte 8'hA5. Expect:
  - req_ready=4'b0100 for 1 cycle, grant_id=2.
  - uart_data=8'hA5 and uart_tx_en rising one cycle later, high for 52096 cycles.
  - `uart_tx` line shows 0,1,0,1,0,0,1,0,1,1 at 5208-cycle spacing.
- Round-robin fairness: all four valid continuously. Accept order 0,1,2,3,0, each accept spaced 52098 cycles apart.
- Fixed priority build (UART_ARB_FIXED_PRIO_EN): all four valid. Requester 0 is granted every frame; requesters 1–3 are never granted.
- Request during busy: req_valid[1] asserted mid-WAIT. No req_ready until the cycle after uart_tx_en falls; the second en rising edge is ≥2 cycles after the fall.
- Reset mid-frame: assert sys_rst_n low at counter=20000. All outputs take reset values asynchronously; after release, a pending req_valid[0] is accepted on the first IDLE cycle.
- Data stability: change req_data[7:0] from 8'h11 to 8'h22 after accept. uart_data stays 8'h11 for the whole frame.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx serializer between four byte requesters.
// Picks a winner, presents its byte on uart_data, then raises uart_tx_en for
// one full frame window before it serves the next byte.
// Build option: define UART_ARB_FIXED_PRIO_EN for lowest-index-wins fixed
// priority. Round-robin is used when the macro is undefined.
module uart_tx_arb #(
  parameter int unsigned SYS_CLK_FRE = 50_000_000,
  parameter int unsigned BPS         = 9_600,
  parameter int unsigned GUARD       = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [7:0]  uart_data,
  output logic        uart_tx_en,
  output logic        busy,
  output logic [1:0]  grant_id
);

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W     = 20;
  localparam int unsigned BPS_CNT   = SYS_CLK_FRE / BPS;
  // Start bit, 8 data bits, stop bit, plus idle guard clocks. This must stay
  // below 2**CNT_W.
  localparam int unsigned FRAME_CNT = 10 * BPS_CNT + GUARD;
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic [DATA_W-1:0]   uart_data_q;
  logic                uart_tx_en_q;
  logic                busy_q;
  logic [ID_W-1:0]     grant_id_q;
  logic [CNT_W-1:0]    frame_cnt_q;
  logic [CNT_W-1:0]    frame_cnt_d;

  logic                win_vld_c;
  logic [ID_W-1:0]     win_id_c;
  logic [ID_W-1:0]     cand_c;
  logic [DATA_W-1:0]   win_data_c;

`ifndef UART_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]     last_grant_q;
`endif

  // Winner selection: take the first pending requester in search order.
  always_comb begin
    win_vld_c = 1'b0;
    win_id_c  = '0;
    cand_c    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      cand_c = ID_W'(i);
`else
      cand_c = last_grant_q + ID_W'(i + 1);
`endif
      if (!win_vld_c && req_valid[cand_c]) begin
        win_vld_c = 1'b1;
        win_id_c  = cand_c;
      end
    end
  end

  assign win_data_c  = req_data[{win_id_c, 3'b000} +: DATA_W];
  assign frame_cnt_d = frame_cnt_q + CNT_W'(1);

  // Scheduler state machine: accept, raise the enable, then hold for one frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= '0;
      uart_data_q  <= '0;
      uart_tx_en_q <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= '0;
      frame_cnt_q  <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      last_grant_q <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      req_ready_q <= '0;
      case (state_q)
        ST_IDLE: begin
          uart_tx_en_q <= 1'b0;
          if (win_vld_c) begin
            req_ready_q  <= NUM_REQ'(1) << win_id_c;
            uart_data_q  <= win_data_c;
            grant_id_q   <= win_id_c;
            busy_q       <= 1'b1;
`ifndef UART_ARB_FIXED_PRIO_EN
            last_grant_q <= win_id_c;
`endif
            state_q      <= ST_START;
          end
        end
        ST_START: begin
          uart_tx_en_q <= 1'b1;
          frame_cnt_q  <= '0;
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (frame_cnt_q == FRAME_LAST) begin
            uart_tx_en_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            frame_cnt_q  <= frame_cnt_d;
          end
        end
        default: begin
          uart_tx_en_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign uart_data  = uart_data_q;
  assign uart_tx_en = uart_tx_en_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized scoreboard bench for uart_tx_arb. The bench uses a shortened
// frame so that every scenario finishes quickly.
module tb_uart_tx_arb;

  localparam int unsigned SYS_CLK_FRE = 1000;
  localparam int unsigned BPS         = 100;
  localparam int unsigned GUARD       = 4;
  localparam int unsigned FRAME_CNT   = 10 * (SYS_CLK_FRE / BPS) + GUARD;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  uart_data;
  logic        uart_tx_en;
  logic        busy;
  logic [1:0]  grant_id;

  uart_tx_arb #(
    .SYS_CLK_FRE(SYS_CLK_FRE),
    .BPS        (BPS),
    .GUARD      (GUARD)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .uart_data (uart_data),
    .uart_tx_en(uart_tx_en),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    bit         b2b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] stim_bytes[4][$];
  int         model_last = 3;
  int         force_byte = -1;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_uart_data"}, 32'(uart_data), 32'h00);
    chk({tag, "_uart_tx_en"}, 32'(uart_tx_en), 32'h0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'h0);
  endtask

  // Reference arbitration rule.
  function automatic int pick(input logic [3:0] m, input int last);
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) if (m[k]) return k;
`else
    for (int k = 1; k <= 4; k++) if (m[(last + k) % 4]) return (last + k) % 4;
`endif
    return 0;
  endfunction

  function automatic logic [7:0] gen_byte();
    if (force_byte >= 0) return 8'(force_byte);
    return 8'($urandom);
  endfunction

  // Transaction-level model. It drains a pending set in order, and it builds
  // the byte lists that the requesters later present.
  task automatic model_run(input logic [3:0] mask0, input int refill, input logic [3:0] late,
                           output int total);
    logic [3:0] set;
    logic [7:0] cur[4];
    int         rf[4];
    bit         first;
    bit         late_done;
    int         w;
    exp_t       e;
    set = mask0;
    total = 0;
    first = 1'b1;
    late_done = (late == 4'h0);
    for (int k = 0; k < 4; k++) begin
      rf[k] = refill;
      cur[k] = 8'h00;
      if (mask0[k]) begin
        cur[k] = gen_byte();
        stim_bytes[k].push_back(cur[k]);
      end
    end
    while (set != 4'h0) begin
      w = pick(set, model_last);
      model_last = w;
      e.id = w;
      e.data = cur[w];
      e.b2b = !first;
      exp_q.push_back(e);
      first = 1'b0;
      total++;
      set[w] = 1'b0;
      if (rf[w] > 0) begin
        rf[w]--;
        set[w] = 1'b1;
        cur[w] = gen_byte();
        stim_bytes[w].push_back(cur[w]);
      end
      if (!late_done) begin
        late_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
          if (late[k] && !set[k]) begin
            set[k] = 1'b1;
            cur[k] = gen_byte();
            stim_bytes[k].push_back(cur[k]);
          end
        end
      end
    end
  endtask

  task automatic arm(input int k);
    req_data[8*k +: 8] = stim_bytes[k].pop_front();
    req_valid[k] = 1'b1;
  endtask

  // Requester behaviour: each requester holds its byte until accepted, then
  // optionally re-arms. Late requests arrive in the middle of the first frame.
  task automatic drive(input logic [3:0] mask0, input int total, input int refill,
                       input logic [3:0] late);
    int rf[4];
    int acc;
    int hi;
    int budget;
    bit late_done;
    acc = 0;
    hi = 0;
    budget = total * (FRAME_CNT + 2) + 40;
    late_done = (late == 4'h0);
    for (int k = 0; k < 4; k++) begin
      rf[k] = refill;
      if (mask0[k]) arm(k);
    end
    while ((acc < total || busy) && budget > 0) begin
      @(posedge sys_clk);
      #1;
      budget--;
      for (int k = 0; k < 4; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          req_valid[k] = 1'b0;
          acc++;
          if (rf[k] > 0) begin
            rf[k]--;
            arm(k);
          end
        end
      end
      if (uart_tx_en) hi++;
      if (!late_done && acc >= 1 && hi >= 10) begin
        late_done = 1'b1;
        for (int k = 0; k < 4; k++) if (late[k] && !req_valid[k]) arm(k);
      end
      for (int k = 0; k < 4; k++) if (!req_valid[k]) req_data[8*k +: 8] = 8'($urandom);
    end
    chk("accept_count", 32'(acc), 32'(total));
  endtask

  // Monitor: pops one expectation per accept pulse and checks frame timing.
  int         cyc = 0;
  int         last_acc = -1;
  int         ready_cyc = -1000;
  int         fall_cyc = -1000;
  int         hi_len = 0;
  logic       prev_en = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  bit         stable_bad = 1'b0;
  exp_t       mon_e;

  always @(negedge sys_clk) begin
    cyc++;
    if (!sys_rst_n) begin
      prev_en = 1'b0;
      hi_len = 0;
      last_acc = -1;
      ready_cyc = -1000;
      fall_cyc = -1000;
    end else begin
      if (req_ready != 4'h0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 32'(req_ready), 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ready_onehot", 32'(req_ready), 32'(1) << mon_e.id);
          chk("grant_id", 32'(grant_id), 32'(mon_e.id));
          chk("uart_data_at_accept", 32'(uart_data), 32'(mon_e.data));
          chk("busy_at_accept", 32'(busy), 32'h1);
          chk("en_low_at_accept", 32'(uart_tx_en), 32'h0);
          if (mon_e.b2b && last_acc >= 0)
            chk("accept_spacing", 32'(cyc - last_acc), 32'(FRAME_CNT + 2));
          last_acc = cyc;
          ready_cyc = cyc;
          cur_byte = mon_e.data;
        end
      end
      if (uart_tx_en && !prev_en) begin
        chk("en_rise_latency", 32'(cyc - ready_cyc), 32'h1);
        chk("ready_pulse_width", 32'(req_ready), 32'h0);
        if (fall_cyc >= 0) chk("en_low_gap_ge2", 32'(cyc - fall_cyc >= 2), 32'h1);
        hi_len = 0;
        stable_bad = 1'b0;
      end
      if (uart_tx_en) begin
        hi_len++;
        if (uart_data !== cur_byte) stable_bad = 1'b1;
      end
      if (!uart_tx_en && prev_en) begin
        chk("en_high_len", 32'(hi_len), 32'(FRAME_CNT));
        chk("data_stable", 32'(stable_bad), 32'h0);
        chk("busy_fall", 32'(busy), 32'h0);
        fall_cyc = cyc;
      end
      prev_en = uart_tx_en;
    end
  end

  initial begin
    int total;
    int m;
    int r;
    int l;
    int waited;
    int hi;
    req_valid = 4'h0;
    req_data = 32'h0;
    #23;
    chk_reset_vals("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Single request from requester 2 with a known byte.
    force_byte = 8'hA5;
    model_run(4'b0100, 0, 4'h0, total);
    force_byte = -1;
    drive(4'b0100, total, 0, 4'h0);

    // Data stability: the requester 0 lane changes after the accept.
    force_byte = 8'h11;
    model_run(4'b0001, 0, 4'h0, total);
    force_byte = -1;
    drive(4'b0001, total, 0, 4'h0);

    // All four requesters stay continuously valid.
    model_run(4'hF, 2, 4'h0, total);
    drive(4'hF, total, 2, 4'h0);

    // A request arrives during busy.
    model_run(4'b0001, 0, 4'b0010, total);
    drive(4'b0001, total, 0, 4'b0010);

    // Random mixes.
    repeat (8) begin
      m = $urandom_range(1, 15);
      r = $urandom_range(0, 2);
      l = $urandom_range(0, 15);
      model_run(4'(m), r, 4'(l), total);
      drive(4'(m), total, r, 4'(l));
    end

    // Reset in the middle of a frame, with requester 0 left pending.
    model_run(4'b0010, 0, 4'h0, total);
    arm(1);
    waited = 0;
    hi = 0;
    while (hi < 30 && waited < 400) begin
      @(posedge sys_clk);
      #1;
      waited++;
      if (req_valid[1] && req_ready[1]) req_valid[1] = 1'b0;
      if (uart_tx_en) hi++;
    end
    chk("reached_mid_frame", 32'(hi), 32'd30);
    model_last = 3;
    model_run(4'b0001, 0, 4'h0, total);
    arm(0);
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("accept_after_reset", 32'(req_ready), 32'h1);
    req_valid[0] = 1'b0;
    waited = 0;
    while ((busy || uart_tx_en) && waited < FRAME_CNT + 20) begin
      @(posedge sys_clk);
      #1;
      waited++;
    end
    chk("post_reset_frame_done", 32'(busy), 32'h0);

    repeat (4) @(posedge sys_clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
